// File: rtl/ahbl_uart_tx.sv
// AHB-Lite transmit-only UART (8N1, LSB first) with a transmit FIFO and a
// programmable baud prescaler. Zero-wait-state slave; registers at [3:2]:
// DATA, STATUS, PRESC, reserved.
module ahbl_uart_tx #(
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter logic [15:0] PRESC_RESET = 16'd433
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic [2:0]  HSIZE,
   input  logic        HWRITE,
   input  logic        HREADY,
   input  logic        HSEL,
   input  logic [31:0] HWDATA,
   output logic        HREADYOUT,
   output logic [31:0] HRDATA,
   output logic        TX,
   output logic        IRQ
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   // Bus capture
   logic       addr_valid;
   logic       wr_q, rd_q;
   logic [1:0] addr_q;

   // Register-mapped state
   logic [15:0] presc_q;
   logic        overflow_q;

   // FIFO
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [PtrW-1:0] wptr_q, rptr_q;
   logic [CntW-1:0] count_q, count_d;
   logic            full, empty, push, push_ok, pop;

   // Transmitter
   state_e      state_q, state_d;
   logic [15:0] baud_q, baud_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        tx;
   logic        busy;

   logic [31:0] cnt_ext;
   logic [3:0]  cnt_field;
   logic [31:0] status;

   logic unused_bits;
   assign unused_bits = ^{HSIZE, HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:16]};

   assign addr_valid = HSEL & HTRANS[1] & HREADY;
   assign HREADYOUT  = 1'b1;

   // Register address phase; cleared whenever no qualified transfer is presented
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         wr_q   <= 1'b0;
         rd_q   <= 1'b0;
         addr_q <= 2'd0;
      end else begin
         wr_q   <= addr_valid & HWRITE;
         rd_q   <= addr_valid & ~HWRITE;
         addr_q <= addr_valid ? HADDR[3:2] : 2'd0;
      end
   end

   assign push    = wr_q && (addr_q == 2'd0);
   assign full    = (count_q == CntW'(FIFO_DEPTH));
   assign empty   = (count_q == '0);
   // A pop frees a slot in the same cycle, so a push to a full FIFO still lands
   assign push_ok = push && (!full || pop);

   // Data-phase register writes and sticky overflow flag
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         presc_q    <= PRESC_RESET;
         overflow_q <= 1'b0;
      end else begin
         if (wr_q && (addr_q == 2'd2)) presc_q <= HWDATA[15:0];
         if (push && !push_ok) begin
            overflow_q <= 1'b1;
         end else if (wr_q && (addr_q == 2'd1) && HWDATA[7]) begin
            overflow_q <= 1'b0;
         end
      end
   end

   // FIFO storage; contents are meaningless once the pointers are reset
   always_ff @(posedge HCLK) begin
      if (push_ok) mem_q[wptr_q] <= HWDATA[7:0];
   end

   // FIFO occupancy next-state
   always_comb begin
      count_d = count_q;
      unique case ({push_ok, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO pointers and count
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_ok) wptr_q <= wptr_q + PtrW'(1);
         if (pop)     rptr_q <= rptr_q + PtrW'(1);
         count_q <= count_d;
      end
   end

   // Transmitter state register
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q <= StIdle;
         baud_q  <= 16'd0;
         bit_q   <= 3'd0;
         shift_q <= 8'd0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   // Transmitter next-state and serial output; each bit lasts PRESC+1 cycles
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
      tx      = 1'b1;
      unique case (state_q)
         StIdle: begin
            if (!empty) begin
               pop     = 1'b1;
               shift_d = mem_q[rptr_q];
               baud_d  = presc_q;
               state_d = StStart;
            end
         end
         StStart: begin
            tx = 1'b0;
            if (baud_q == 16'd0) begin
               baud_d  = presc_q;
               bit_d   = 3'd0;
               state_d = StData;
            end else begin
               baud_d = baud_q - 16'd1;
            end
         end
         StData: begin
            tx = shift_q[0];
            if (baud_q == 16'd0) begin
               baud_d  = presc_q;
               shift_d = shift_q >> 1;
               if (bit_q == 3'd7) begin
                  state_d = StStop;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               baud_d = baud_q - 16'd1;
            end
         end
         StStop: begin
            if (baud_q == 16'd0) begin
               // Chain straight into the next frame when data is waiting
               if (!empty) begin
                  pop     = 1'b1;
                  shift_d = mem_q[rptr_q];
                  baud_d  = presc_q;
                  state_d = StStart;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               baud_d = baud_q - 16'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign busy = (state_q != StIdle);
   assign TX   = tx;
   assign IRQ  = (empty && !busy) || overflow_q;

   // Status word; count field saturates at 4 bits
   always_comb begin
      cnt_ext   = 32'(count_q);
      cnt_field = (cnt_ext > 32'd15) ? 4'hF : cnt_ext[3:0];
      status    = {24'd0, overflow_q, cnt_field, busy, empty, full};
   end

   // Read data for the captured address; zero outside a read data phase
   always_comb begin
      HRDATA = 32'd0;
      if (rd_q) begin
         unique case (addr_q)
            2'd1:    HRDATA = status;
            2'd2:    HRDATA = {16'd0, presc_q};
            default: HRDATA = 32'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_ahbl_uart_tx.sv
// Directed + randomized bench for ahbl_uart_tx. Expected serial waveforms come
// from a frame model (start, 8 data bits LSB first, stop, each PRESC+1 cycles).
module tb_ahbl_uart_tx;

   localparam logic [31:0] Base = 32'h8000_0000;
   localparam int unsigned Depth = 8;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   logic        HWRITE;
   logic        HREADY;
   logic        HSEL;
   logic [31:0] HWDATA;
   logic        HREADYOUT;
   logic [31:0] HRDATA;
   logic        TX;
   logic        IRQ;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [7:0] exp_bytes[$];

   ahbl_uart_tx #(
      .FIFO_DEPTH (Depth),
      .PRESC_RESET(16'd433)
   ) dut (
      .HCLK     (HCLK),
      .HRESET   (HRESET),
      .HADDR    (HADDR),
      .HTRANS   (HTRANS),
      .HSIZE    (HSIZE),
      .HWRITE   (HWRITE),
      .HREADY   (HREADY),
      .HSEL     (HSEL),
      .HWDATA   (HWDATA),
      .HREADYOUT(HREADYOUT),
      .HRDATA   (HRDATA),
      .TX       (TX),
      .IRQ      (IRQ)
   );

   always #5 HCLK = ~HCLK;
   always @(posedge HCLK) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic model_bit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return b[k-1];
   endfunction

   function automatic logic [31:0] model_status(input int cnt, input bit busy, input bit ov);
      return {24'd0, ov, 4'(cnt), busy, (cnt == 0), (cnt == Depth)};
   endfunction

   task automatic bus_write(input logic [31:0] off, input logic [31:0] data);
      HADDR  = Base + off;
      HTRANS = 2'b10;
      HWRITE = 1'b1;
      HSEL   = 1'b1;
      HREADY = 1'b1;
      @(posedge HCLK); #1;
      HSEL   = 1'b0;
      HTRANS = 2'b00;
      HWRITE = 1'b0;
      HWDATA = data;
      @(posedge HCLK); #1;
   endtask

   task automatic bus_read(input logic [31:0] off, output logic [31:0] data);
      HADDR  = Base + off;
      HTRANS = 2'b10;
      HWRITE = 1'b0;
      HSEL   = 1'b1;
      HREADY = 1'b1;
      @(posedge HCLK); #1;
      HSEL   = 1'b0;
      HTRANS = 2'b00;
      data   = HRDATA;
   endtask

   task automatic push_all();
      foreach (exp_bytes[i]) bus_write(32'h0, {24'd0, exp_bytes[i]});
   endtask

   // Finds the first start bit, then checks every cycle of all queued frames
   task automatic tx_monitor(input int p);
      int found = 0;
      int total;
      for (int i = 0; i < 20 && found == 0; i++) begin
         @(posedge HCLK); #1;
         if (TX === 1'b0) found = 1;
      end
      check("tx_start_seen", found, 1);
      total = exp_bytes.size() * 10 * (p + 1);
      if (found == 1) begin
         for (int n = 0; n < total; n++) begin
            if (n > 0) begin
               @(posedge HCLK); #1;
            end
            check("tx_bit", TX, model_bit(exp_bytes[n / (10 * (p + 1))], (n / (p + 1)) % 10));
         end
      end
   endtask

   task automatic send_and_check(input int p);
      logic [31:0] rd;
      fork
         push_all();
         tx_monitor(p);
      join
      @(posedge HCLK); #1;
      check("irq_after_frames", IRQ, 1);
      bus_read(32'h4, rd);
      check("status_after_frames", rd, 32'h2);
   endtask

   initial begin
      logic [31:0] rd;
      int p, n, m_cnt, c0, target;
      bit m_ov;

      HRESET = 1'b1;
      HADDR  = 32'd0;
      HTRANS = 2'b00;
      HSIZE  = 3'b010;
      HWRITE = 1'b0;
      HREADY = 1'b1;
      HSEL   = 1'b0;
      HWDATA = 32'd0;

      // Reset state
      repeat (3) @(posedge HCLK);
      #1;
      check("rst_tx", TX, 1);
      check("rst_irq", IRQ, 1);
      check("rst_hreadyout", HREADYOUT, 1);
      check("rst_hrdata", HRDATA, 32'h0);
      HRESET = 1'b0;
      @(posedge HCLK); #1;
      bus_read(32'h4, rd);
      check("rst_status", rd, 32'h2);
      bus_read(32'h8, rd);
      check("rst_presc", rd, 32'h1B1);
      @(posedge HCLK); #1;
      check("hrdata_idle", HRDATA, 32'h0);

      // Unqualified transfers must not push
      HADDR = Base; HSEL = 1'b1; HWRITE = 1'b1; HTRANS = 2'b00; HREADY = 1'b1;
      @(posedge HCLK); #1;
      HWDATA = 32'h55; HTRANS = 2'b10; HREADY = 1'b0;
      @(posedge HCLK); #1;
      HSEL = 1'b0; HWRITE = 1'b0; HTRANS = 2'b00; HREADY = 1'b1;
      @(posedge HCLK); #1;
      bus_read(32'h4, rd);
      check("unqualified_no_push", rd, 32'h2);
      check("unqualified_tx", TX, 1);
      bus_read(32'hC, rd);
      check("reserved_read", rd, 32'h0);
      bus_write(32'hC, 32'h0000_FFFF);
      bus_read(32'h8, rd);
      check("reserved_write_ignored", rd, 32'h1B1);
      bus_read(32'h0, rd);
      check("data_reads_zero", rd, 32'h0);

      // Single byte
      bus_write(32'h8, 32'hFFFF_0003);
      bus_read(32'h8, rd);
      check("presc_rw", rd, 32'h3);
      exp_bytes = '{8'hA5};
      send_and_check(3);

      // Back-to-back frames at one cycle per bit
      bus_write(32'h8, 32'h0);
      exp_bytes = '{8'h01, 8'h02, 8'h03};
      send_and_check(0);

      // Randomized payloads and prescalers
      for (int r = 0; r < 4; r++) begin
         p = $urandom_range(0, 3);
         n = $urandom_range(1, 5);
         exp_bytes.delete();
         for (int i = 0; i < n; i++) exp_bytes.push_back(8'($urandom));
         bus_write(32'h8, 32'(p));
         send_and_check(p);
      end

      // Overflow: first byte goes to the shifter, next eight fill the FIFO
      p = 100;
      bus_write(32'h8, 32'(p));
      exp_bytes.delete();
      for (int i = 0; i < 10; i++) exp_bytes.push_back(8'($urandom));
      bus_write(32'h0, {24'd0, exp_bytes[0]});
      c0 = cyc;
      m_cnt = 0;
      m_ov = 1'b0;
      for (int i = 1; i < 10; i++) begin
         bus_write(32'h0, {24'd0, exp_bytes[i]});
         if (m_cnt < Depth) m_cnt++;
         else m_ov = 1'b1;
      end
      bus_read(32'h4, rd);
      check("ovf_status", rd, model_status(m_cnt, 1'b1, m_ov));
      check("ovf_irq", IRQ, 1);
      bus_write(32'h4, 32'h80);
      bus_read(32'h4, rd);
      check("ovf_cleared", rd, model_status(m_cnt, 1'b1, 1'b0));
      @(posedge HCLK); #1;
      check("irq_low_busy", IRQ, 0);

      // Reset in the middle of data bit 3 of the first frame
      target = c0 + 1 + 4 * (p + 1) + (p + 1) / 2;
      while (cyc < target) @(posedge HCLK);
      #1;
      check("mid_frame_bit3", TX, model_bit(exp_bytes[0], 4));
      #2;
      HRESET = 1'b1;
      #1;
      check("mid_reset_tx", TX, 1);
      check("mid_reset_irq", IRQ, 1);
      @(posedge HCLK); #1;
      HRESET = 1'b0;
      @(posedge HCLK); #1;
      bus_read(32'h4, rd);
      check("mid_reset_status", rd, 32'h2);
      bus_read(32'h8, rd);
      check("mid_reset_presc", rd, 32'h1B1);
      repeat (5) begin
         @(posedge HCLK); #1;
         check("post_reset_tx_idle", TX, 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ahbl_uart_tx.md
Name: ahbl_uart_tx

Overview:
AHB-Lite slave peripheral providing a transmit-only UART (8N1, LSB first) with an 8-entry transmit FIFO and a programmable baud prescaler. It sits on one splitter slave port (S3, base 0x8000_0000) alongside program memory, data memory and GPIO. The CPU pushes bytes over the bus and polls status; the block serialises bytes on TX autonomously.

Parameters:
FIFO_DEPTH, 8, transmit FIFO entries; power of two, minimum 2
PRESC_RESET, 16'd433, prescaler reset value; bit period = PRESC+1 HCLK cycles

Ports:
HCLK  input  1  bus and core clock
HRESET  input  1  reset, asynchronous, active-high
HADDR  input  32  address; bits [3:2] decoded, others ignored
HTRANS  input  2  transfer type; HTRANS[1]=1 means active (NONSEQ/SEQ)
HSIZE  input  3  ignored; all accesses treated as word
HWRITE  input  1  1=write
HREADY  input  1  bus-wide ready; qualifies address phase
HSEL  input  1  slave select from splitter
HWDATA  input  32  write data (data phase)
HREADYOUT  output  1  always 1 (zero wait states)
HRDATA  output  32  read data (data phase)
TX  output  1  serial output, idle high
IRQ  output  1  high when FIFO empty and shifter idle, or overflow flag set

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. All state cleared on HRESET assertion regardless of HCLK.
- Reset values: HREADYOUT=1, HRDATA=0, TX=1, IRQ=1 (empty+idle), FIFO empty, PRESC=PRESC_RESET, overflow=0, FSM=IDLE.
- Address phase captured when HSEL & HTRANS[1] & HREADY: register wr_en, rd_en, addr[3:2]. Capture clears otherwise.
- Data phase (next cycle): writes use HWDATA; HRDATA combinational from captured address; HRDATA=0 when no read in data phase.
- Register map (offset): 0x0 DATA (W: push HWDATA[7:0]; R: 0). 0x4 STATUS (R: [0] full, [1] empty, [2] busy, [6:3] fifo count, [7] overflow; W: writing 1 to bit 7 clears overflow). 0x8 PRESC (R/W [15:0]; upper bits read 0). 0xC reserved: reads 0, writes ignored.
- Push to full FIFO: data dropped, overflow set (sticky). Push and pop in same cycle when full: pop occurs, push accepted, count unchanged, no overflow.
- FIFO: circular, read/write pointers wrap at FIFO_DEPTH; count 0..FIFO_DEPTH; count field saturates bit width 4 (DEPTH=8 -> max 8).
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  IDLE: TX=1; if FIFO non-empty, pop into shift register, load baud counter with PRESC, go START.
  START: TX=0 for PRESC+1 cycles.
  DATA: TX=shift[0]; each bit PRESC+1 cycles; shift right; 8 bits then STOP.
  STOP: TX=1 for PRESC+1 cycles; then if FIFO non-empty pop directly and go START (back-to-back frames, no idle cycle), else IDLE.
- Frame length exactly 10*(PRESC+1) cycles. PRESC written mid-frame takes effect at next bit-counter reload.
- busy=1 in any state other than IDLE.
- PRESC=0 is legal: one cycle per bit.
- HRESET mid-frame: TX returns to 1 immediately (asynchronously), FIFO contents discarded.

Test Plan:
- Reset: assert HRESET -> TX=1, IRQ=1, read STATUS=0x0000_0002, read PRESC=0x0000_01B1.
- Single byte: write PRESC=3, write DATA=0xA5 -> TX low 4 cycles, then bits 1,0,1,0,0,1,0,1 each 4 cycles, stop high 4 cycles; busy clears after 40 cycles; IRQ returns to 1.
- Back-to-back: PRESC=0, push 0x01,0x02,0x03 -> 30 contiguous TX cycles, no idle between frames, STATUS empty=1 afterwards.
- Overflow: PRESC=100, push 9 bytes quickly -> first popped into shifter, 8 held, 9th... push 10 -> STATUS[7]=1, IRQ=1; write STATUS=0x80 -> bit7=0.
- Bus qualification: HSEL=1 with HTRANS=IDLE or HREADY=0 write to DATA -> FIFO count unchanged; reserved 0xC read returns 0.
- Reset mid-frame: assert HRESET during DATA bit 3 -> TX=1 same cycle, STATUS after release =0x0000_0002.
